// File: rtl/mem_port_arbiter.sv
// Arbitrates one SRAM-like bus port between instruction fetch and data access.
// Each access runs address phase, then data phase, then a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq
);

  localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {G_NONE, G_INST, G_DATA} grant_e;

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                wr_q, wr_d;
  logic [31:0]         inst_rdata_q, inst_rdata_d;
  logic [31:0]         data_rdata_q, data_rdata_d;
  logic                inst_ready_q, inst_ready_d;
  logic                data_ready_q, data_ready_d;
  logic                streak_full;

  assign streak_full = (streak_q == STREAK_W'(DATA_STREAK_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      grant_q      <= G_NONE;
      streak_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wr_q         <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      streak_q     <= streak_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wr_q         <= wr_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    streak_d     = streak_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wr_d         = wr_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Data wins by default unless it has already starved a pending fetch long enough.
        if (data_req && !(inst_req && streak_full)) begin
          grant_d = G_DATA;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          wstrb_d = data_wen;
          wr_d    = |data_wen;
          state_d = S_ADDR;
          if (!inst_req) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (inst_req) begin
          grant_d  = G_INST;
          addr_d   = inst_addr;
          wdata_d  = '0;
          wstrb_d  = '0;
          wr_d     = 1'b0;
          streak_d = '0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_data_ok) begin
          state_d = S_RESP;
          if (grant_q == G_INST) begin
            inst_rdata_d = bus_rdata;
            inst_ready_d = 1'b1;
          end else begin
            data_rdata_d = bus_rdata;
            data_ready_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        // Requests are not looked at here: the requester may still show its finished req.
        grant_d = G_NONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus_req    = (state_q == S_ADDR);
  assign bus_wr     = wr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign inst_ready = inst_ready_q;
  assign data_rdata = data_rdata_q;
  assign data_ready = data_ready_q;
  assign stallreq   = (inst_req & ~inst_ready_q) | (data_req & ~data_ready_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like bus port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Sequences each access as an address phase followed by a data phase, and returns the read data and a one-cycle ready pulse to the granted requester.
- Raises a stall request to the pipeline controller while any requester is waiting for its access to complete.
- Sits between the pipeline stages and the top-level memory interface.

Parameters:
DATA_STREAK_MAX, 4, maximum consecutive data grants while an instruction request is pending; after that many, the next grant goes to instruction.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous, active-low reset
inst_req  input  1  fetch request; held high until inst_ready
inst_addr  input  32  fetch address; stable while inst_req is high
inst_rdata  output  32  fetched instruction; valid while inst_ready is high
inst_ready  output  1  one-cycle pulse: fetch complete
data_req  input  1  load/store request; held high until data_ready
data_wen  input  4  byte write enables; 0 means read
data_addr  input  32  load/store address
data_wdata  input  32  store data
data_rdata  output  32  load data; valid while data_ready is high
data_ready  output  1  one-cycle pulse: access complete
bus_req  output  1  address-phase request
bus_wr  output  1  1 = write
bus_wstrb  output  4  byte strobes, copy of data_wen for data grants, 0 for instruction grants
bus_addr  output  32  access address
bus_wdata  output  32  write data
bus_addr_ok  input  1  address phase accepted this cycle
bus_data_ok  input  1  data phase complete this cycle
bus_rdata  input  32  read data, valid with bus_data_ok
stallreq  output  1  pipeline stall request

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE; streak counter = 0; grant register = none.
  - bus_req, inst_ready, data_ready = 0; inst_rdata, data_rdata, bus_addr, bus_wdata = 0; bus_wr = 0; bus_wstrb = 0.
  - Reset may hit mid-transaction; a bus_data_ok arriving after reset is ignored because the FSM is in IDLE.
- FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - Samples the requests. If none is high, stay in IDLE.
  - Default priority is data over instruction.
  - Exception: if both requests are high and streak == DATA_STREAK_MAX, grant instruction.
  - On a grant, register the grant, the address, wdata and strobes; bus_wr = |data_wen for data grants, else 0. Go to ADDR.
- ADDR: bus_req = 1 with the registered fields held. When bus_addr_ok = 1, drop bus_req the next cycle and go to WAIT.
- WAIT: bus_req = 0. When bus_data_ok = 1, latch bus_rdata into the granted requester's rdata register and go to RESP.
- RESP:
  - The granted requester's ready = 1 for exactly this cycle; always go to IDLE next.
  - Requests are not sampled in RESP, because a requester may still show its old req.
  - rdata registers hold their value until the next completion for that port.
- Streak counter:
  - On a data grant with inst_req high: increment, saturating at DATA_STREAK_MAX.
  - On any instruction grant: clear to 0.
  - On a data grant with inst_req low: clear to 0.
- Latency: req sampled in IDLE at cycle N → bus_req high in N+1 → addr_ok at the earliest in N+1 → data_ok at the earliest in N+2 → ready in N+3. The next request is sampled in N+4.
- bus_addr_ok and bus_data_ok outside ADDR and WAIT respectively are ignored. bus_data_ok in the same cycle as addr_ok is not supported; the bus guarantees it does not happen.
- For writes, data_rdata is still loaded with bus_rdata; requesters ignore it.
- stallreq = (inst_req & ~inst_ready) | (data_req & ~data_ready). It is combinational and has no reset dependency beyond the ready registers.
- Addresses are passed through unmodified; there is no alignment check.

Test Plan:
- Single fetch: after reset, inst_req=1 with addr 0xbfc0_0000; addr_ok in the first ADDR cycle; data_ok 1 cycle later with rdata 0x2408_0001 → bus_addr=0xbfc0_0000, bus_wr=0, inst_ready pulses once with inst_rdata=0x2408_0001, 3 cycles after the req was sampled, stallreq low in the ready cycle.
- Simultaneous requests: inst_req and data_req (load 0x8000_0010) both high in IDLE → data is granted first (bus_addr=0x8000_0010), instruction is granted in the IDLE following data_ready, and stallreq stays high until inst_ready.
- Starvation guard: data_req re-asserted continuously with inst_req held high → exactly 4 data grants, then the instruction grant, then the streak restarts from 0.
- Store: data_wen=4'b0011, addr 0x8000_0020, wdata 0x1234_5678 → bus_wr=1, bus_wstrb=4'b0011, bus_wdata=0x1234_5678, held while addr_ok stays low for 5 cycles, then data_ready after data_ok.
- Back-pressure: addr_ok held low for 10 cycles → bus_req and all bus fields remain stable, and no ready pulse occurs.
- Reset mid-op: resetn driven low in WAIT → outputs cleared immediately; a stale data_ok 2 cycles after reset release produces no ready pulse.
